acc_out_packer: RTL

- Consumer end of the accumulation/requantization output interface.
- Accepts saturated Tout-lane result words on a valid-only (non-stallable) strobe and buffers them in a small FIFO.
- Serializes each word into narrower beats on an AXI-stream-style valid/ready master port, tagging the last beat of a tile.
- Sits between the accumulation stage and the output DMA write path.

---
 rtl/acc_out_packer_if.sv | 23 ++
 rtl/acc_out_packer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/acc_out_packer_if.sv
// Output beat stream of the accumulation result packer (valid/ready, last-beat tag).
interface acc_out_packer_if #(
    parameter int unsigned OUT_W = 64
) ();
    logic [OUT_W-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        output m_tready
    );
endinterface

// File: rtl/acc_out_packer.sv
// Buffers wide requantized result words from a non-stallable producer and
// serializes each one into OUT_W beats on a valid/ready stream, tagging the tile's last beat.
module acc_out_packer #(
    parameter int unsigned LANE_W     = 8,
    parameter int unsigned TOUT       = 32,
    parameter int unsigned OUT_W      = 64,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       tile_len,
    input  logic [LANE_W*TOUT-1:0] dat_i,
    input  logic                   dat_vld_i,
    acc_out_packer_if.master       strm,
    output logic                   almost_full,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int unsigned IN_W  = LANE_W * TOUT;
    localparam int unsigned BEATS = IN_W / OUT_W;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [AW:0]       OCC_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]       OCC_AF    = (AW+1)'(FIFO_DEPTH - 2);
    localparam logic [AW:0]       OCC_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]     PTR_ONE   = AW'(1);
    localparam logic [BW-1:0]     BEAT_LAST = BW'(BEATS - 1);
    localparam logic [BW-1:0]     BEAT_ONE  = BW'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [IN_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      occ;
    logic [CNT_W-1:0] len_q, in_cnt, out_cnt;
    logic [BW-1:0]    beat_idx;

    logic [BEATS-1:0][OUT_W-1:0] head_beats;

    logic full, tvalid, beat_last, hs, pop, wr_en, drop;
    logic word_last, tile_end, start_ok, start_zero;

    always_comb begin
        full       = (occ == OCC_FULL);
        tvalid     = (occ != '0);
        beat_last  = (beat_idx == BEAT_LAST);
        hs         = tvalid & strm.m_tready;
        pop        = hs & beat_last;
        // a pop in the same cycle frees the slot, so a full FIFO can still take the word
        wr_en      = (state_q == S_RUN) & dat_vld_i & (~full | pop);
        drop       = dat_vld_i & ~wr_en;
        word_last  = (out_cnt == len_q - CNT_ONE);
        tile_end   = (state_q == S_DRAIN) & pop & word_last;
        start_ok   = (state_q == S_IDLE) & start & (tile_len != '0);
        start_zero = (state_q == S_IDLE) & start & (tile_len == '0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (wr_en && (in_cnt + CNT_ONE == len_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tile_end) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Storage is intentionally unreset; occupancy gates everything read from it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            len_q    <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            beat_idx <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= tile_end | start_zero;

            if (start_ok) begin
                len_q    <= tile_len;
                in_cnt   <= '0;
                out_cnt  <= '0;
                beat_idx <= '0;
                overflow <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
            end

            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                in_cnt <= in_cnt + CNT_ONE;
            end

            if (hs) begin
                beat_idx <= beat_last ? '0 : beat_idx + BEAT_ONE;
            end

            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                out_cnt <= out_cnt + CNT_ONE;
            end

            case ({wr_en, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    always_comb begin
        head_beats    = mem[rd_ptr];
        strm.m_tvalid = tvalid;
        strm.m_tdata  = tvalid ? head_beats[beat_idx] : '0;
        strm.m_tlast  = tvalid & beat_last & word_last;
        almost_full   = (occ >= OCC_AF);
        busy          = (state_q != S_IDLE);
    end

endmodule
